// File: rtl/alu_exec_if.sv
// Handshake bundle between operand fetch, the execute ALU and writeback.
// The master side is the producer/consumer pair; the slave side is the ALU.
interface alu_exec_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, alu_ctl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, alu_ctl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU with a one-deep registered output and valid/ready flow control.
// Define ALU_MUL_EN to add the WIDTH-cycle iterative shift-add multiplier (code 16).
module alu_exec #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave io
);
  localparam int MSB = WIDTH - 1;
  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_OR  = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_SUB = 5'd6;
  localparam logic [4:0] OP_SLT = 5'd7;
  localparam logic [4:0] OP_NOR = 5'd8;
  localparam logic [4:0] OP_XOR = 5'd9;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } rsp_t;

  rsp_t             rsp_q, rsp_d;
  logic             out_valid_q;
  logic             free, accept, is_mul;
  logic [WIDTH-1:0] sum, diff;

  assign free   = !out_valid_q || io.out_ready;
  assign accept = io.in_valid && io.in_ready;
  assign sum    = io.op_a + io.op_b;
  assign diff   = io.op_a - io.op_b;

  // Single-cycle datapath; unknown codes fall through to the illegal response.
  always_comb begin
    rsp_d = '0;
    case (io.alu_ctl)
      OP_AND: rsp_d.result = io.op_a & io.op_b;
      OP_OR:  rsp_d.result = io.op_a | io.op_b;
      OP_ADD: begin
        rsp_d.result = sum;
        rsp_d.ovf    = (io.op_a[MSB] == io.op_b[MSB]) && (sum[MSB] != io.op_a[MSB]);
      end
      OP_SUB: begin
        rsp_d.result = diff;
        rsp_d.ovf    = (io.op_a[MSB] != io.op_b[MSB]) && (diff[MSB] != io.op_a[MSB]);
      end
      // Full signed compare so the answer stays right when a-b overflows.
      OP_SLT: rsp_d.result = {{(WIDTH-1){1'b0}}, ($signed(io.op_a) < $signed(io.op_b))};
      OP_NOR: rsp_d.result = ~(io.op_a | io.op_b);
      OP_XOR: rsp_d.result = io.op_a ^ io.op_b;
      default: rsp_d.illegal = 1'b1;
    endcase
    rsp_d.zero = (rsp_d.result == '0);
  end

`ifdef ALU_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd16;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step, mul_res;
  logic [CW-1:0]    cnt;
  logic             done, last;
  rsp_t             mul_rsp;

  assign is_mul      = (io.alu_ctl == OP_MUL);
  assign last        = (cnt == CW'(WIDTH - 1));
  assign acc_step    = acc + (mplier[0] ? mcand : '0);
  // Final step and hand-off share an edge when the output is free; once done, acc is final.
  assign mul_res     = done ? acc : acc_step;
  assign mul_rsp     = '{result: mul_res, zero: (mul_res == '0), ovf: 1'b0, illegal: 1'b0};
  assign io.in_ready = (state == IDLE) && free && !rst;
`else
  assign is_mul      = 1'b0;
  assign io.in_ready = free && !rst;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
`endif
    end else begin
      if (free) out_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        rsp_q       <= rsp_d;
        out_valid_q <= 1'b1;
      end
`ifdef ALU_MUL_EN
      case (state)
        IDLE: if (accept && is_mul) begin
          mcand  <= io.op_a;
          mplier <= io.op_b;
          acc    <= '0;
          cnt    <= '0;
          done   <= 1'b0;
          state  <= BUSY;
        end
        BUSY: begin
          if (!done) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (last) done <= 1'b1;
            else      cnt  <= cnt + 1'b1;
          end
          if ((done || last) && free) begin
            rsp_q       <= mul_rsp;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.result    = rsp_q.result;
  assign io.zero      = rsp_q.zero;
  assign io.ovf       = rsp_q.ovf;
  assign io.illegal   = rsp_q.illegal;
endmodule
